// File: rtl/restoring_divider.sv
// Sequential unsigned radix-2 restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, valid/ready handshakes on input and output.
module restoring_divider #(
    parameter int DATA_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0]   divisor,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   quotient,
    output logic [DATA_WIDTH-1:0]   remainder,
    output logic                    overflow,
    output logic                    div_by_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    rem_q;
    logic [W-1:0]    qshift_q;
    logic [W-1:0]    divisor_q;
    logic [CW-1:0]   count_q;

    logic [W:0]      shifted;
    logic            q_bit;
    logic [W-1:0]    rem_sub;
    logic [W-1:0]    rem_next;
    logic [W-1:0]    q_next;
    logic            accept;
    logic            ovf_in;
    logic            last;

    // rem < divisor always holds, so only the low W bits of the partial
    // remainder are stored; the carry-out bit lives only in 'shifted'.
    always_comb begin
        shifted  = {rem_q, qshift_q[W-1]};
        q_bit    = (shifted >= {1'b0, divisor_q});
        rem_sub  = shifted[W-1:0] - divisor_q;
        rem_next = q_bit ? rem_sub : shifted[W-1:0];
        q_next   = {qshift_q[W-2:0], q_bit};
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid && (state_q == IDLE);
    assign ovf_in    = (divisor == '0) || (dividend[2*W-1:W] >= divisor);
    assign last      = (count_q == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = ovf_in ? DONE : CALC;
            CALC: if (last) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            qshift_q    <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            divisor_q <= divisor;
            if (ovf_in) begin
                quotient    <= '1;
                remainder   <= '0;
                overflow    <= 1'b1;
                div_by_zero <= (divisor == '0);
            end else begin
                rem_q    <= dividend[2*W-1:W];
                qshift_q <= dividend[W-1:0];
                count_q  <= CW'(W);
            end
        end else if (state_q == CALC) begin
            rem_q    <= rem_next;
            qshift_q <= q_next;
            count_q  <= count_q - CW'(1);
            if (last) begin
                quotient    <= q_next;
                remainder   <= rem_next;
                overflow    <= 1'b0;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: W=8 and W=128 instances checked
// against a plain-arithmetic division model with directed and random operands.
module tb_restoring_divider;

    logic clk;
    logic rst_n;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0]  a_dividend;
    logic [7:0]   a_divisor, a_quotient, a_remainder;
    logic         a_overflow, a_div_by_zero;

    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [255:0] b_dividend;
    logic [127:0] b_divisor, b_quotient, b_remainder;
    logic         b_overflow, b_div_by_zero;

    int checks;
    int failures;

    restoring_divider #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .dividend(a_dividend), .divisor(a_divisor),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .quotient(a_quotient), .remainder(a_remainder),
        .overflow(a_overflow), .div_by_zero(a_div_by_zero)
    );

    restoring_divider #(.DATA_WIDTH(128)) dut128 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .dividend(b_dividend), .divisor(b_divisor),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .quotient(b_quotient), .remainder(b_remainder),
        .overflow(b_overflow), .div_by_zero(b_div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: quotient must fit w bits, otherwise saturate with overflow.
    task automatic model(input logic [255:0] dvd, input logic [255:0] dvs, input int w,
                         output logic [255:0] q, output logic [255:0] r,
                         output logic ovf, output logic dbz);
        logic [255:0] qq;
        dbz = (dvs == 0);
        if (dbz) begin
            ovf = 1'b1;
            q   = (256'd1 << w) - 1;
            r   = 0;
        end else begin
            qq = dvd / dvs;
            if ((qq >> w) != 0) begin
                ovf = 1'b1;
                q   = (256'd1 << w) - 1;
                r   = 0;
            end else begin
                ovf = 1'b0;
                q   = qq;
                r   = dvd % dvs;
            end
        end
    endtask

    task automatic run8(input logic [15:0] dvd, input logic [7:0] dvs, input bit hold);
        logic [255:0] eq, er;
        logic         eo, ez;
        int           edges;
        model({240'd0, dvd}, {248'd0, dvs}, 8, eq, er, eo, ez);
        @(negedge clk);
        a_in_valid = 1'b1;
        a_dividend = dvd;
        a_divisor  = dvs;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_dividend = 16'($urandom);
        a_divisor  = 8'($urandom);
        edges = 0;
        while (!a_out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("w8_out_valid", {255'd0, a_out_valid}, 256'd1);
        chk("w8_latency", edges, eo ? 0 : 8);
        chk("w8_quotient", {248'd0, a_quotient}, eq);
        chk("w8_remainder", {248'd0, a_remainder}, er);
        chk("w8_overflow", {255'd0, a_overflow}, {255'd0, eo});
        chk("w8_div_by_zero", {255'd0, a_div_by_zero}, {255'd0, ez});
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                a_in_valid = 1'b1;
                a_dividend = 16'($urandom);
                a_divisor  = 8'($urandom);
                @(posedge clk);
                #1;
                chk("hold_out_valid", {255'd0, a_out_valid}, 256'd1);
                chk("hold_in_ready", {255'd0, a_in_ready}, 256'd0);
                chk("hold_quotient", {248'd0, a_quotient}, eq);
                chk("hold_remainder", {248'd0, a_remainder}, er);
            end
            @(negedge clk);
            a_in_valid = 1'b0;
        end
        @(negedge clk);
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        chk("w8_handshake_valid", {255'd0, a_out_valid}, 256'd0);
        chk("w8_handshake_in_ready", {255'd0, a_in_ready}, 256'd1);
        chk("w8_quotient_kept", {248'd0, a_quotient}, eq);
    endtask

    task automatic run128(input logic [255:0] dvd, input logic [127:0] dvs);
        logic [255:0] eq, er;
        logic         eo, ez;
        int           edges;
        model(dvd, {128'd0, dvs}, 128, eq, er, eo, ez);
        @(negedge clk);
        b_in_valid = 1'b1;
        b_dividend = dvd;
        b_divisor  = dvs;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_dividend = '0;
        b_divisor  = '0;
        edges = 0;
        while (!b_out_valid && edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("w128_out_valid", {255'd0, b_out_valid}, 256'd1);
        chk("w128_latency", edges, eo ? 0 : 128);
        chk("w128_quotient", {128'd0, b_quotient}, eq);
        chk("w128_remainder", {128'd0, b_remainder}, er);
        chk("w128_overflow", {255'd0, b_overflow}, {255'd0, eo});
        @(negedge clk);
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        chk("w128_handshake_valid", {255'd0, b_out_valid}, 256'd0);
    endtask

    initial begin
        logic [127:0] ka, kb;
        logic [7:0]   dvs, hi, lo;
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        a_dividend  = '0;
        a_divisor   = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        b_dividend  = '0;
        b_divisor   = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {255'd0, a_in_ready}, 256'd1);
        chk("rst_out_valid", {255'd0, a_out_valid}, 256'd0);
        chk("rst_quotient", {248'd0, a_quotient}, 256'd0);
        chk("rst_remainder", {248'd0, a_remainder}, 256'd0);
        chk("rst_overflow", {254'd0, a_overflow, a_div_by_zero}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run8(16'h1234, 8'h56, 1'b0);
        run8(16'hFE01, 8'hFF, 1'b0);
        run8(16'h5600, 8'h56, 1'b0);
        run8(16'h0001, 8'h00, 1'b0);
        run8(16'h0000, 8'h01, 1'b0);
        run8(16'h1234, 8'h56, 1'b1);

        // Abort mid-calculation with async reset, then rerun the same operation.
        @(negedge clk);
        a_in_valid = 1'b1;
        a_dividend = 16'h1234;
        a_divisor  = 8'h56;
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {255'd0, a_out_valid}, 256'd0);
        chk("abort_in_ready", {255'd0, a_in_ready}, 256'd1);
        chk("abort_quotient", {248'd0, a_quotient}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_result", {255'd0, a_out_valid}, 256'd0);
        run8(16'h1234, 8'h56, 1'b0);

        for (int i = 0; i < 30; i++) begin
            dvs = 8'($urandom);
            lo  = 8'($urandom);
            if (i % 3 == 0 || dvs == 0) hi = 8'($urandom);
            else hi = 8'($urandom_range(int'(dvs) - 1, 0));
            run8({hi, lo}, dvs, 1'b0);
        end

        ka = 128'hDEADBEEFCAFEBABE123456789ABCDEF0;
        kb = 128'h0123456789ABCDEFDEADBEEFCAFEBABE;
        run128({128'd0, ka} * {128'd0, kb}, ka);
        ka = '1;
        run128({128'd0, ka} * {128'd0, ka}, ka);
        run128({128'd5, 128'd0}, 128'd5);
        for (int i = 0; i < 3; i++) begin
            ka = {$urandom, $urandom, $urandom, $urandom};
            kb = {$urandom, $urandom, $urandom, $urandom};
            run128({128'd0, ka} * {128'd0, kb} + {128'd0, 128'(kb >> 1)}, kb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
